// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control path: opcodes, functs, ALU codes, FSM states, mux selects.
// Imported by the multicycle sequencer and by the ALU control decoder.
package cpu_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2A;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  // Coarse ALU request from the sequencer; the decoder refines AluOpFunct using funct.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StWbMem   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StWbAlu   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StTrap    = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcAluOut = 2'b01,
    PcSrcJump   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    SrcBRt     = 2'b00,
    SrcBFour   = 2'b01,
    SrcBImm    = 2'b10,
    SrcBImmSh2 = 2'b11
  } alu_src_b_e;

  function automatic logic funct_is_legal(input logic [5:0] funct);
    return (funct == FunctAdd) || (funct == FunctSub) || (funct == FunctAnd) ||
           (funct == FunctOr)  || (funct == FunctSlt);
  endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// Maps the sequencer's coarse ALU request plus funct to the 4-bit ALU operation.
// Purely combinational so the single-cycle CPU can reuse it unchanged.
module alu_control_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluAdd;
    case (alu_op_i)
      AluOpSub: alu_control_o = AluSub;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: alu_control_o = AluAdd;
          FunctSub: alu_control_o = AluSub;
          FunctAnd: alu_control_o = AluAnd;
          FunctOr:  alu_control_o = AluOr;
          FunctSlt: alu_control_o = AluSlt;
          default:  alu_control_o = AluAdd;
        endcase
      end
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle CPU: walks the shared datapath through fetch/decode/execute/
// memory/writeback and issues every mux select and write strobe each cycle.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         TRAP_STICKY = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       alu_zero_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_control_o,
  output logic       instr_retired_o,
  output logic       illegal_instr_o,
  output logic [3:0] state_out_o
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, funct_q;

  logic       pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw;
  logic       reg_write_raw, retired_raw;
  logic       illegal, iord, reg_dst, mem_to_reg, alu_src_a;
  pc_src_e    pc_src;
  alu_src_b_e alu_src_b;
  alu_op_e    alu_op;
  logic       strobe_en;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= state_e'(RESET_STATE);
    end else if (enable_i) begin
      state_q <= state_d;
    end
  end

  // Later states decode from the latched copy, so the IR may change once DECODE is done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode_q <= '0;
      funct_q  <= '0;
    end else if (enable_i && (state_q == StDecode)) begin
      opcode_q <= opcode_i;
      funct_q  <= funct_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = funct_is_legal(funct_i) ? StExecR : StTrap;
          OpAddi:     state_d = StExecI;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = StWbMem;
      StExecR:   state_d = StWbAlu;
      StExecI:   state_d = StWbAlu;
      StWbMem, StMemWr, StWbAlu, StBranch, StJump: state_d = StFetch;
      StTrap:    state_d = TRAP_STICKY ? StTrap : StFetch;
      default:   state_d = StFetch;
    endcase
  end

  // Moore output decode; strobes are gated separately below
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    retired_raw   = 1'b0;
    illegal       = 1'b0;
    pc_src        = PcSrcAlu;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBRt;
    alu_op        = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        mem_read_raw = 1'b1;
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_src_b    = SrcBFour;
      end
      StDecode: alu_src_b = SrcBImmSh2;
      StMemAddr, StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        iord         = 1'b1;
        mem_read_raw = 1'b1;
      end
      StWbMem: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        retired_raw   = 1'b1;
      end
      StMemWr: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        retired_raw   = 1'b1;
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
      end
      StWbAlu: begin
        reg_write_raw = 1'b1;
        reg_dst       = (opcode_q == OpRtype);
        retired_raw   = 1'b1;
      end
      StBranch: begin
        alu_src_a    = 1'b1;
        alu_op       = AluOpSub;
        pc_src       = PcSrcAluOut;
        pc_write_raw = alu_zero_i;
        retired_raw  = 1'b1;
      end
      StJump: begin
        pc_write_raw = 1'b1;
        pc_src       = PcSrcJump;
        retired_raw  = 1'b1;
      end
      StTrap:  illegal = 1'b1;
      default: ;
    endcase
  end

  alu_control_decoder u_alu_control_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (funct_q),
    .alu_control_o (alu_control_o)
  );

  // Reset state is FETCH, but no strobe may fire while reset is still held.
  assign strobe_en = enable_i & rst_ni;

  assign pc_write_o      = pc_write_raw  & strobe_en;
  assign ir_write_o      = ir_write_raw  & strobe_en;
  assign mem_read_o      = mem_read_raw  & strobe_en;
  assign mem_write_o     = mem_write_raw & strobe_en;
  assign reg_write_o     = reg_write_raw & strobe_en;
  assign instr_retired_o = retired_raw   & strobe_en;
  assign illegal_instr_o = illegal;
  assign pc_src_o        = pc_src;
  assign iord_o          = iord;
  assign reg_dst_o       = reg_dst;
  assign mem_to_reg_o    = mem_to_reg;
  assign alu_src_a_o     = alu_src_a;
  assign alu_src_b_o     = alu_src_b;
  assign state_out_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multicycle sequencer: directed table, hand-written corner sequences and a random
// instruction stream checked against a per-instruction schedule model.
module tb_multicycle_control_fsm;
  import cpu_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic [5:0] opcode_i = '0;
  logic [5:0] funct_i = '0;
  logic       alu_zero_i = 1'b0;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       retired;
    logic       illegal;
  } outs_t;

  typedef enum {KLw, KSw, KR, KAddi, KBeq, KJ, KIll} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         len;
    int         regw;
    int         memw;
    int         ret;
    int         pcw;
    int         ill;
  } vec_t;

  logic n_pc_write, n_ir_write, n_mem_read, n_mem_write, n_iord, n_reg_write, n_reg_dst;
  logic n_mem_to_reg, n_alu_src_a, n_retired, n_illegal;
  logic [1:0] n_pc_src, n_alu_src_b;
  logic [3:0] n_alu_control, n_state;
  logic s_pc_write, s_ir_write, s_mem_read, s_mem_write, s_iord, s_reg_write, s_reg_dst;
  logic s_mem_to_reg, s_alu_src_a, s_retired, s_illegal;
  logic [1:0] s_pc_src, s_alu_src_b;
  logic [3:0] s_alu_control, s_state;
  outs_t n_act, s_act;

  assign n_act = {n_pc_write, n_pc_src, n_ir_write, n_mem_read, n_mem_write, n_iord, n_reg_write,
                  n_reg_dst, n_mem_to_reg, n_alu_src_a, n_alu_src_b, n_alu_control, n_retired,
                  n_illegal};
  assign s_act = {s_pc_write, s_pc_src, s_ir_write, s_mem_read, s_mem_write, s_iord, s_reg_write,
                  s_reg_dst, s_mem_to_reg, s_alu_src_a, s_alu_src_b, s_alu_control, s_retired,
                  s_illegal};

  int checks = 0;
  int errors = 0;
  logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0] bad_op [5] = '{6'h3F, 6'h01, 6'h10, 6'h20, 6'h2C};
  logic [5:0] bad_fn [5] = '{6'h08, 6'h00, 6'h21, 6'h26, 6'h2B};

  always #5 clk_i = ~clk_i;

  multicycle_control_fsm #(.RESET_STATE(4'd0), .TRAP_STICKY(1'b0)) dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .opcode_i(opcode_i),
    .funct_i(funct_i), .alu_zero_i(alu_zero_i), .pc_write_o(n_pc_write), .pc_src_o(n_pc_src),
    .ir_write_o(n_ir_write), .mem_read_o(n_mem_read), .mem_write_o(n_mem_write),
    .iord_o(n_iord), .reg_write_o(n_reg_write), .reg_dst_o(n_reg_dst),
    .mem_to_reg_o(n_mem_to_reg), .alu_src_a_o(n_alu_src_a), .alu_src_b_o(n_alu_src_b),
    .alu_control_o(n_alu_control), .instr_retired_o(n_retired), .illegal_instr_o(n_illegal),
    .state_out_o(n_state)
  );

  multicycle_control_fsm #(.RESET_STATE(4'd0), .TRAP_STICKY(1'b1)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .opcode_i(opcode_i),
    .funct_i(funct_i), .alu_zero_i(alu_zero_i), .pc_write_o(s_pc_write), .pc_src_o(s_pc_src),
    .ir_write_o(s_ir_write), .mem_read_o(s_mem_read), .mem_write_o(s_mem_write),
    .iord_o(s_iord), .reg_write_o(s_reg_write), .reg_dst_o(s_reg_dst),
    .mem_to_reg_o(s_mem_to_reg), .alu_src_a_o(s_alu_src_a), .alu_src_b_o(s_alu_src_b),
    .alu_control_o(s_alu_control), .instr_retired_o(s_retired), .illegal_instr_o(s_illegal),
    .state_out_o(s_state)
  );

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return KLw;
      6'h2B: return KSw;
      6'h08: return KAddi;
      6'h04: return KBeq;
      6'h02: return KJ;
      6'h00: begin
        foreach (legal_fn[i]) if (legal_fn[i] == fn) return KR;
        return KIll;
      end
      default: return KIll;
    endcase
  endfunction

  function automatic int instr_len(input kind_e k);
    case (k)
      KLw:                 return 5;
      KSw, KR, KAddi:      return 4;
      default:             return 3;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [3:0] state_of(input kind_e k, input int step);
    if (step == 0) return StFetch;
    if (step == 1) return StDecode;
    case (k)
      KLw:     return (step == 2) ? StMemAddr : (step == 3) ? StMemRd : StWbMem;
      KSw:     return (step == 2) ? StMemAddr : StMemWr;
      KR:      return (step == 2) ? StExecR : StWbAlu;
      KAddi:   return (step == 2) ? StExecI : StWbAlu;
      KBeq:    return StBranch;
      KJ:      return StJump;
      default: return StTrap;
    endcase
  endfunction

  function automatic outs_t strobe_mask();
    outs_t m = '0;
    m.pc_write = 1'b1; m.ir_write = 1'b1; m.mem_read = 1'b1; m.mem_write = 1'b1;
    m.reg_write = 1'b1; m.retired = 1'b1; m.illegal = 1'b1;
    return m;
  endfunction

  // Expected outputs for cycle `step` of an instruction; m marks the fields the cycle defines.
  function automatic void model(input kind_e k, input int step, input logic [5:0] fn,
                                input logic zero, input logic en, output outs_t e, output outs_t m);
    e = '0;
    m = strobe_mask();
    if (step == 0) begin
      e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
      m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_control = '1; m.pc_src = '1;
    end else if (step == 1) begin
      e.alu_src_b = 2'b11; e.alu_control = 4'b0010;
      m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_control = '1;
    end else if ((step == 2) && (k != KBeq) && (k != KJ) && (k != KIll)) begin
      e.alu_src_a = 1'b1;
      e.alu_src_b = (k == KR) ? 2'b00 : 2'b10;
      e.alu_control = (k == KR) ? alu_of(fn) : 4'b0010;
      m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_control = '1;
    end else begin
      case (k)
        KLw: begin
          if (step == 3) begin
            e.iord = 1'b1; e.mem_read = 1'b1; m.iord = 1'b1;
          end else begin
            e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retired = 1'b1;
            m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
          end
        end
        KSw: begin
          e.iord = 1'b1; e.mem_write = 1'b1; e.retired = 1'b1; m.iord = 1'b1;
        end
        KR, KAddi: begin
          e.reg_write = 1'b1; e.reg_dst = (k == KR); e.retired = 1'b1;
          m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
        end
        KBeq: begin
          e.alu_src_a = 1'b1; e.alu_control = 4'b0110; e.pc_src = 2'b01;
          e.pc_write = zero; e.retired = 1'b1;
          m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_control = '1; m.pc_src = '1;
        end
        KJ: begin
          e.pc_write = 1'b1; e.pc_src = 2'b10; e.retired = 1'b1; m.pc_src = '1;
        end
        default: e.illegal = 1'b1;
      endcase
    end
    if (!en) begin
      e.pc_write = 1'b0; e.ir_write = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
      e.reg_write = 1'b0; e.retired = 1'b0;
    end
  endfunction

  task automatic check_outs(input string name, input outs_t act, input outs_t e, input outs_t m);
    checks++;
    if (((act ^ e) & m) != '0) begin
      errors++;
      $display("FAIL %s: outputs got %h required %h (care mask %h)", name, act, e, m);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Leaves both DUTs in FETCH with enable low, positioned just after a falling edge.
  task automatic do_reset();
    @(negedge clk_i);
    enable_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Runs one instruction on the non-sticky DUT, checking every cycle including stalled ones.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int stall_pct, input int force_step);
    kind_e k;
    int    len;
    int    stalls;
    logic  en;
    outs_t e, m;
    k = classify(op, fn);
    len = instr_len(k);
    opcode_i = op;
    funct_i = fn;
    for (int step = 0; step < len; step++) begin
      stalls = 0;
      do begin
        if ((step == force_step) && (stalls < 3)) en = 1'b0;
        else if ((stalls < 2) && ($urandom_range(99) < 32'(stall_pct))) en = 1'b0;
        else en = 1'b1;
        if (!en) stalls++;
        enable_i = en;
        alu_zero_i = 1'($urandom_range(1));
        #1;
        model(k, step, fn, alu_zero_i, en, e, m);
        check_outs($sformatf("%s step%0d en%0d", tag, step, en), n_act, e, m);
        check_int($sformatf("%s state step%0d", tag, step), int'(n_state),
                  int'(state_of(k, step)));
        @(negedge clk_i);
      end while (!en);
    end
  endtask

  initial begin
    vec_t  vecs[11];
    outs_t e, m;
    int    cyc, regw, memw, ret, pcw, ill;
    logic [5:0] op, fn;

    vecs[0]  = '{6'h23, 6'h00, 1'b0, 5, 1, 0, 1, 1, 0};
    vecs[1]  = '{6'h2B, 6'h00, 1'b0, 4, 0, 1, 1, 1, 0};
    vecs[2]  = '{6'h00, 6'h20, 1'b0, 4, 1, 0, 1, 1, 0};
    vecs[3]  = '{6'h00, 6'h22, 1'b0, 4, 1, 0, 1, 1, 0};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 4, 1, 0, 1, 1, 0};
    vecs[5]  = '{6'h08, 6'h15, 1'b0, 4, 1, 0, 1, 1, 0};
    vecs[6]  = '{6'h04, 6'h00, 1'b1, 3, 0, 0, 1, 2, 0};
    vecs[7]  = '{6'h04, 6'h00, 1'b0, 3, 0, 0, 1, 1, 0};
    vecs[8]  = '{6'h02, 6'h00, 1'b0, 3, 0, 0, 1, 2, 0};
    vecs[9]  = '{6'h3F, 6'h00, 1'b0, 3, 0, 0, 0, 1, 1};
    vecs[10] = '{6'h00, 6'h08, 1'b0, 3, 0, 0, 0, 1, 1};

    // Reset values
    #2;
    e = '0; e.alu_control = 4'b0010;
    m = strobe_mask(); m.pc_src = '1; m.alu_control = '1;
    check_int("reset state", int'(n_state), int'(StFetch));
    check_outs("reset outputs", n_act, e, m);
    do_reset();

    // Directed table: latency and strobe counts per instruction, enable held high
    foreach (vecs[i]) begin
      opcode_i = vecs[i].op; funct_i = vecs[i].fn; alu_zero_i = vecs[i].zero; enable_i = 1'b1;
      #1;
      cyc = 0; regw = 0; memw = 0; ret = 0; pcw = 0; ill = 0;
      do begin
        regw += int'(n_reg_write); memw += int'(n_mem_write); ret += int'(n_retired);
        pcw += int'(n_pc_write); ill += int'(n_illegal);
        cyc++;
        @(negedge clk_i);
        #1;
      end while ((n_state != StFetch) && (cyc < 12));
      check_int($sformatf("vec%0d latency", i), cyc, vecs[i].len);
      check_int($sformatf("vec%0d reg_write cycles", i), regw, vecs[i].regw);
      check_int($sformatf("vec%0d mem_write cycles", i), memw, vecs[i].memw);
      check_int($sformatf("vec%0d retire pulses", i), ret, vecs[i].ret);
      check_int($sformatf("vec%0d pc_write cycles", i), pcw, vecs[i].pcw);
      check_int($sformatf("vec%0d illegal cycles", i), ill, vecs[i].ill);
    end

    // Asynchronous reset in the middle of MEM_RD
    do_reset();
    opcode_i = 6'h23; funct_i = 6'h00; enable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check_int("pre-reset in MEM_RD", int'(n_state), int'(StMemRd));
    rst_ni = 1'b0;
    #1;
    e = '0; e.alu_control = 4'b0010;
    m = strobe_mask(); m.pc_src = '1; m.alu_control = '1;
    check_int("async reset state", int'(n_state), int'(StFetch));
    check_outs("async reset outputs", n_act, e, m);
    check_outs("async reset outputs sticky", s_act, e, m);
    rst_ni = 1'b1;
    #1;
    model(KLw, 0, 6'h00, 1'b0, 1'b1, e, m);
    check_outs("post-reset fetch", n_act, e, m);
    enable_i = 1'b0;

    // Enable dropped for three cycles in EXEC_R of a sub, then an sw
    do_reset();
    run_instr("sub stall", 6'h00, 6'h22, 0, 2);
    run_instr("sw", 6'h2B, 6'h11, 0, -1);
    run_instr("beq", 6'h04, 6'h00, 0, -1);

    // Sticky versus non-sticky trap, for a bad opcode and a bad R-type funct
    for (int t = 0; t < 2; t++) begin
      do_reset();
      opcode_i = (t == 0) ? 6'h3F : 6'h00;
      funct_i = (t == 0) ? 6'h00 : 6'h08;
      enable_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
        alu_zero_i = 1'($urandom_range(1));
        #1;
        if (c >= 2) begin
          model(KIll, 2, 6'h00, 1'b0, 1'b1, e, m);
          check_outs($sformatf("sticky trap t%0d c%0d", t, c), s_act, e, m);
          check_int($sformatf("sticky state t%0d c%0d", t, c), int'(s_state), int'(StTrap));
        end
        if (c == 2) check_int($sformatf("pulse trap t%0d", t), int'(n_illegal), 1);
        if (c == 3) begin
          check_int($sformatf("pulse clear t%0d", t), int'(n_illegal), 0);
          check_int($sformatf("pulse refetch t%0d", t), int'(n_state), int'(StFetch));
        end
        @(negedge clk_i);
      end
    end

    // Random instruction stream with random stalls
    do_reset();
    for (int n = 0; n < 60; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(6))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin op = 6'h00; fn = legal_fn[$urandom_range(4)]; end
        3: op = 6'h08;
        4: op = 6'h04;
        5: op = 6'h02;
        default: begin
          if ($urandom_range(1) == 0) op = bad_op[$urandom_range(4)];
          else begin op = 6'h00; fn = bad_fn[$urandom_range(4)]; end
        end
      endcase
      run_instr($sformatf("rand%0d op%h fn%h", n, op, fn), op, fn, 25, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control sequencer for the multicycle variant of the CPU.
- Steps the shared datapath through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK: one register file, one ALU, one unified instruction/data memory, plus IR, MDR and ALUOut holding registers.
- Issues every mux select and write strobe each cycle.
- Supports lw, sw, R-type (add, sub, and, or, slt), addi, beq and j. Traps anything else.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.
- TRAP_STICKY, 1: 1 means illegal_instr holds until reset; 0 means it pulses for one cycle, then the FSM re-fetches.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  advance permission; low freezes the FSM
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- pc_write  out  1  PC load strobe
- pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- ir_write  out  1  IR load strobe
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- reg_write  out  1  register file write strobe
- reg_dst  out  1  destination: 1 = rd, 0 = rt
- mem_to_reg  out  1  write-back data: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_control  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- instr_retired  out  1  one-cycle pulse in the final state of each instruction
- illegal_instr  out  1  trap flag
- state_out  out  4  current state, for debug

Behaviour:
- Reset:
  - Asynchronous; state goes to FETCH immediately.
  - All strobes and flags are 0, pc_src = 00, alu_control = 0010.
  - Opcode/funct latches clear to 0.
- Enable:
  - enable = 0: state holds; pc_write, ir_write, mem_read, mem_write, reg_write and instr_retired are forced 0; mux selects are unchanged.
  - enable = 1: one state transition per rising edge.
- Outputs are Moore-decoded from the state register plus the latched opcode/funct. Strobes are combinational from state and gated by enable.
- FETCH: iord = 0, mem_read, ir_write, alu_src_a = 0, alu_src_b = 01, add, pc_write, pc_src = 00. Next state DECODE.
- DECODE:
  - Latch opcode/funct. alu_src_a = 0, alu_src_b = 11, add (branch target goes into ALUOut).
  - Next state: 0x23/0x2B → MEM_ADDR; 0x00 with legal funct → EXEC_R; 0x08 → EXEC_I; 0x04 → BRANCH; 0x02 → JUMP; otherwise → TRAP.
  - Legal funct values: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, add. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord = 1, mem_read. Next state WB_MEM.
- WB_MEM: reg_write, reg_dst = 0, mem_to_reg = 1, retire. Next state FETCH.
- MEM_WR: iord = 1, mem_write, retire. Next state FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_control from funct. Next state WB_ALU.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, add. Next state WB_ALU.
- WB_ALU: reg_write, mem_to_reg = 0, reg_dst = 1 for R-type and 0 for addi, retire. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01, pc_write = alu_zero, retire. Next state FETCH.
- JUMP: pc_write, pc_src = 10, retire. Next state FETCH.
- TRAP:
  - illegal_instr = 1; no strobes asserted.
  - TRAP_STICKY = 1: stay in TRAP until reset.
  - TRAP_STICKY = 0: one cycle in TRAP, then FETCH.
- Latencies in enabled cycles: beq/j 3, R-type/addi/sw 4, lw 5.
- Only one of mem_read, mem_write, reg_write is active in any cycle, except FETCH, where mem_read is asserted together with ir_write and pc_write.
- Unused state encodings go to FETCH with no strobes.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode and funct constants;
  - ALU control codes;
  - the state enumeration (4-bit);
  - the pc_src and alu_src_b encodings.
- Sub-module alu_control_decoder: combinational; inputs (alu_op[1:0], funct), output alu_control. Also reused by the single-cycle CPU.

Test Plan:
- Reset low mid-MEM_RD → state_out = FETCH and all strobes 0 the same cycle. After release with enable = 1, FETCH strobes appear: mem_read = ir_write = pc_write = 1.
- lw (opcode 0x23) with enable held high → states FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM; reg_write = 1 with mem_to_reg = 1 only in cycle 5; instr_retired pulses once.
- R-type funct 0x22 → alu_control = 0110 in EXEC_R; WB_ALU has reg_dst = 1. Then sw 0x2B → mem_write = 1 in cycle 4 only, reg_write never asserted.
- beq with alu_zero = 1 → pc_write = 1, pc_src = 01 in cycle 3. Repeat with alu_zero = 0 → pc_write = 0; both runs return to FETCH.
- enable dropped for 3 cycles inside EXEC_R → state_out frozen and strobes 0 for those cycles; the sequence resumes with no skipped state.
- opcode 0x3F, and separately R-type funct 0x08 → TRAP with illegal_instr = 1 and no further pc_write. With TRAP_STICKY = 0 the FSM returns to FETCH after one cycle.
